// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the dot-product sequencer in front of the 8x8->16 MAC.
package mac_seq_pkg;

  localparam int OP_W  = 8;
  localparam int ACC_W = 16;

  localparam logic [ACC_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [ACC_W-1:0] SAT_NEG = 16'h8000;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/mac_dot_seq_if.sv
// Job control, operand stream, MAC hookup and result port of mac_dot_seq.
interface mac_dot_seq_if import mac_seq_pkg::*; #(
  parameter int LEN_W = 8
) ();

  logic              start;
  logic [LEN_W-1:0]  len;
  logic              op_vld;
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic              op_rdy;
  logic [OP_W-1:0]   mac_a;
  logic [OP_W-1:0]   mac_b;
  logic              mac_clr_n;
  logic [ACC_W-1:0]  mac_acc;
  logic              mac_of;
  logic              mac_uf;
  logic              res_vld;
  logic [ACC_W-1:0]  res;
  logic              res_of;
  logic              res_uf;
  logic              res_rdy;
  logic              busy;

  modport slave (
    input  start, len, op_vld, op_a, op_b, mac_acc, mac_of, mac_uf, res_rdy,
    output op_rdy, mac_a, mac_b, mac_clr_n, res_vld, res, res_of, res_uf, busy
  );

  modport master (
    output start, len, op_vld, op_a, op_b, mac_acc, mac_of, mac_uf, res_rdy,
    input  op_rdy, mac_a, mac_b, mac_clr_n, res_vld, res, res_of, res_uf, busy
  );

endinterface

// File: rtl/mac_op_fifo.sv
// Synchronous {a,b} operand-pair FIFO; head is visible combinationally, no empty bypass.
module mac_op_fifo import mac_seq_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W     = 2 * OP_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: clears the MAC, streams len operand pairs, captures the sum.
// Build option MAC_SAT_EN saturates the captured result using the sticky flags.
module mac_dot_seq import mac_seq_pkg::*; #(
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  mac_dot_seq_if.slave  bus
);

  state_t                   state;
  state_t                   state_nxt;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         cnt;
  logic [2*OP_W-1:0]        head;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     issue;
  logic                     last;
  logic                     issue_p1;
  logic                     of_q;
  logic                     uf_q;
  logic signed [ACC_W-1:0]  res_q;
  logic [OP_W-1:0]          a_c;
  logic [OP_W-1:0]          b_c;
  logic                     clr_n_c;
  logic                     job_start;

`ifdef MAC_SAT_EN
  logic of_fin;
  logic uf_fin;

  function automatic logic signed [ACC_W-1:0] sat_res(
    input logic                    of,
    input logic                    uf,
    input logic signed [ACC_W-1:0] acc
  );
    if (of)      return $signed(SAT_POS);
    else if (uf) return $signed(SAT_NEG);
    else         return acc;
  endfunction

  assign of_fin = of_q | (issue_p1 & bus.mac_of);
  assign uf_fin = uf_q | (issue_p1 & bus.mac_uf);
`endif

  assign push      = bus.op_vld & ~full;
  assign issue     = (state == ACCUM) & ~empty;
  assign last      = issue & (cnt == len_q - 1'b1);
  assign job_start = (state == IDLE) & bus.start;

  mac_op_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (issue),
    .din   ({bus.op_a, bus.op_b}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_nxt = state;
    a_c       = '0;
    b_c       = '0;
    clr_n_c   = 1'b1;
    case (state)
      IDLE:  if (bus.start) state_nxt = (bus.len == '0) ? DONE : CLEAR;
      CLEAR: begin
        clr_n_c   = 1'b0;
        state_nxt = ACCUM;
      end
      ACCUM: begin
        // An empty FIFO issues a zero bubble so the MAC holds its sum.
        if (issue) begin
          a_c = head[2*OP_W-1:OP_W];
          b_c = head[OP_W-1:0];
        end
        if (last) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = DONE;
      DONE:  if (bus.res_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: MAC flags arrive one cycle after the term that caused them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len_q    <= '0;
      cnt      <= '0;
      issue_p1 <= 1'b0;
      of_q     <= 1'b0;
      uf_q     <= 1'b0;
      res_q    <= '0;
    end else begin
      state    <= state_nxt;
      issue_p1 <= issue;
      if (job_start) len_q <= bus.len;
      if (state == CLEAR)  cnt <= '0;
      else if (issue)      cnt <= cnt + 1'b1;
      if (job_start || state == CLEAR) begin
        of_q <= 1'b0;
        uf_q <= 1'b0;
      end else if (issue_p1) begin
        of_q <= of_q | bus.mac_of;
        uf_q <= uf_q | bus.mac_uf;
      end
      if (job_start) begin
        res_q <= '0;
      end else if (state == DRAIN) begin
`ifdef MAC_SAT_EN
        res_q <= sat_res(of_fin, uf_fin, bus.mac_acc);
`else
        res_q <= bus.mac_acc;
`endif
      end
    end
  end

  assign bus.op_rdy    = ~full;
  assign bus.mac_a     = a_c;
  assign bus.mac_b     = b_c;
  assign bus.mac_clr_n = clr_n_c;
  assign bus.res_vld   = (state == DONE);
  assign bus.res       = res_q;
  assign bus.res_of    = of_q;
  assign bus.res_uf    = uf_q;
  assign bus.busy      = (state != IDLE);

endmodule
